if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first PC fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-004 SHALL have port imem_addr, output, 32, the byte PC presented to the instruction memory; the memory returns registered data one cycle later.
REQ-005 SHALL have port imem_rdata, input, 32, the instruction word for the imem_addr of the previous cycle.
REQ-006 SHALL have port redirect_valid, input, 1, a branch/jump taken from the execute stage.
REQ-007 SHALL have port redirect_pc, input, 32, the redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port out_valid, output, 1, meaning the IF/ID output holds a valid instruction.
REQ-009 SHALL have port out_ready, input, 1, meaning the decode stage accepts the output this cycle.
REQ-010 SHALL have port out_instr, output, 32, the fetched instruction.
REQ-011 SHALL have port out_pc, output, 32, the PC of out_instr.

Function
REQ-012 SHALL hold state pc_q (drives imem_addr), inflight_v/inflight_pc (the request issued last cycle), and a 2-entry FIFO of {pc, instr}.
REQ-013 SHALL define a transfer as out_valid and out_ready both high in the same cycle; payload stays stable while out_valid=1 and out_ready=0.
REQ-014 SHALL drive the output from the FIFO head when count>0; otherwise it SHALL drive {inflight_pc, imem_rdata} directly (bypass) with out_valid=inflight_v.
REQ-015 SHALL push the arriving {inflight_pc, imem_rdata} into the FIFO when inflight_v=1 and the word is not consumed by a bypass transfer the same cycle.
REQ-016 SHALL compute occ_next = count + push - pop, and SHALL issue (pc_q <= pc_q+4, inflight_v <= 1, inflight_pc <= pc_q) iff occ_next <= 1.
REQ-017 SHALL otherwise hold pc_q and set inflight_v <= 0; the memory re-reads the same address harmlessly.
REQ-018 SHALL sustain one instruction per cycle when out_ready is held at 1, with no bubbles after the first.
REQ-019 SHALL have a latency of 1 cycle from issue of address A to out_valid with out_pc=A, given an empty FIFO.
REQ-020 SHALL give redirect_valid=1 priority over all else: FIFO flushed (count=0), inflight_v <= 0 then re-set by issuing redirect_pc, pc_q <= {redirect_pc[31:2],2'b00}+4, inflight_pc <= aligned redirect_pc.
REQ-021 SHALL force out_valid=0 in a redirect cycle; no transfer occurs and no older instruction is delivered afterwards.
REQ-022 SHALL deliver the redirect target exactly 1 cycle after the redirect cycle.
REQ-023 SHALL wrap PC increment modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-024 SHALL never overflow the FIFO (count<=2), and SHALL never push and pop the same entry in one cycle except through the bypass path.

Reset
REQ-025 SHALL, on rst_n=0 (asynchronous): pc_q=RESET_PC, imem_addr=RESET_PC, inflight_v=0, inflight_pc=0, count=0, out_valid=0.
REQ-026 SHALL issue RESET_PC in the first cycle after rst_n deasserts, giving out_valid=1 with out_pc=RESET_PC in the second.
REQ-027 SHALL discard all FIFO contents and in-flight requests on reset asserted mid-operation.

Structure
REQ-028 SHALL have a shared package fetch_pkg holding: XLEN=32, NOP=32'h0000_0013, the RESET_PC default, and the typedef fetch_entry_t {pc, instr}.
REQ-029 SHALL implement the FIFO as one sub-module, fetch_skid_fifo (2 entries, push/pop/flush, count output); PC and issue logic stay in the top module.

Verification
REQ-030 SHALL verify reset/streaming: RESET_PC=0, out_ready=1, memory word[i]=i+1 -> out_pc 0,4,8,... on consecutive cycles, out_instr 1,2,3,...
REQ-031 SHALL verify backpressure: stream, then out_ready=0 for 5 cycles -> count reaches 2, imem_addr frozen, out_pc stable; on release, order continues with no loss or duplicate.
REQ-032 SHALL verify redirect: redirect_valid=1, redirect_pc=32'h0000_0103 with FIFO full -> out_valid=0 that cycle; next cycle out_pc=32'h100; stale PCs never appear.
REQ-033 SHALL verify simultaneous redirect and stall: redirect with out_ready=0 -> flush still occurs and the target is delivered 1 cycle later.
REQ-034 SHALL verify wrap: redirect_pc=32'hFFFF_FFF8 with streaming -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 SHALL verify mid-stall reset: rst_n pulsed low with count=2 -> out_valid=0 immediately, then restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: word width, NOP encoding, default reset PC, queue entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid queue holding fetched {pc, instr} words that decode has not yet taken.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             drop all contents (wins over push/pop)
//   push, push_entry  write an entry at the tail
//   pop               retire the head entry
//   head              current head entry (valid when count != 0)
//   count             occupancy, 0..2
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues sequential PCs to a registered-read memory and hands {pc, instr} to decode.
// Latency: 1 cycle from address issue to out_valid when the queue is empty; redirect target 1 cycle after redirect.
// Backpressure: valid/ready on the output; a 2-entry skid queue absorbs in-flight words, issue stops when it would overfill.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   imem_addr / imem_rdata       memory address out, registered read data back one cycle later
//   redirect_valid, redirect_pc  taken branch/jump from execute (low two target bits ignored)
//   out_valid, out_ready         handshake towards decode
//   out_instr, out_pc            delivered instruction and its PC
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0]  pc_q;
  logic         inflight_v;
  logic [31:0]  inflight_pc;

  logic [31:0]  redirect_aligned;
  fetch_entry_t arriving;
  fetch_entry_t fifo_head;
  logic [1:0]   fifo_count;
  logic         fifo_push;
  logic         fifo_pop;
  logic         xfer;
  logic [2:0]   occ_next;
  logic         issue;

  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  // On a redirect the memory must read the target this very cycle so that it
  // returns one cycle later; otherwise the registered PC addresses memory.
  assign imem_addr = redirect_valid ? redirect_aligned : pc_q;

  assign arriving.pc    = inflight_pc;
  assign arriving.instr = imem_rdata;

  // Queue head takes precedence; with an empty queue the arriving word is
  // bypassed straight to decode. Nothing is offered in a redirect cycle.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = inflight_pc;
    out_instr = imem_rdata;
    if (fifo_count != 2'd0) begin
      out_valid = 1'b1;
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
    end else begin
      out_valid = inflight_v;
    end
    if (redirect_valid) out_valid = 1'b0;
  end

  assign xfer      = out_valid && out_ready;
  assign fifo_pop  = xfer && (fifo_count != 2'd0);
  // The arriving word is queued unless it went out through the bypass.
  assign fifo_push = inflight_v && !redirect_valid && !(xfer && (fifo_count == 2'd0));

  // Issue only if the word it produces next cycle is guaranteed a slot.
  assign occ_next = {1'b0, fifo_count} + {2'b00, fifo_push} - {2'b00, fifo_pop};
  assign issue    = (occ_next <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_q        <= redirect_aligned + 32'd4;
      inflight_v  <= 1'b1;
      inflight_pc <= redirect_aligned;
    end else if (issue) begin
      pc_q        <= pc_q + 32'd4;
      inflight_v  <= 1'b1;
      inflight_pc <= pc_q;
    end else begin
      // Hold: the memory harmlessly re-reads pc_q and the result is ignored.
      inflight_v  <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (arriving),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks;
  int n_errors;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instruction memory: word i holds i+1.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expect a valid word at pc this cycle.
  task automatic expect_word(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"},    out_pc,             pc);
    check({tag, ".instr"}, out_instr,          mem_word(pc));
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Reset state
    #2;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.addr",  imem_addr,          32'h0);
    check("rst.count", {30'd0, dut.fifo_count}, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("rel.valid", {31'd0, out_valid}, 32'd0);
    check("rel.addr",  imem_addr,          32'h0);

    // Streaming: one word per cycle, 0,4,8,... with instr 1,2,3,...
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      settle();
      expect_word("stream", 32'(i * 4));
    end

    // Backpressure: five stalled cycles holding pc 24
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      out_ready = 1'b0;
      settle();
      expect_word("stall", 32'd24);
      if (s >= 1) check("stall.addr", imem_addr, 32'd32);
    end
    check("stall.count", {30'd0, dut.fifo_count}, 32'd2);

    // Release: order continues with no loss or duplicate
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      out_ready = 1'b1;
      settle();
      expect_word("release", 32'(24 + i * 4));
    end

    // Fill the queue, then redirect to 0x103
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      out_ready = 1'b0;
      settle();
      expect_word("fill", 32'd48);
    end
    check("fill.count", {30'd0, dut.fifo_count}, 32'd2);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    out_ready      = 1'b1;
    settle();
    check("redir.valid", {31'd0, out_valid}, 32'd0);
    check("redir.addr",  imem_addr,          32'h100);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      redirect_valid = 1'b0;
      settle();
      expect_word("redir.tgt", 32'(32'h100 + i * 4));
    end

    // Redirect while stalled
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    out_ready      = 1'b0;
    settle();
    check("rstall.valid", {31'd0, out_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    expect_word("rstall.tgt", 32'h200);
    check("rstall.count", {30'd0, dut.fifo_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      out_ready = 1'b1;
      settle();
      expect_word("rstall.run", 32'(32'h200 + i * 4));
    end

    // Wrap-around of the PC increment
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    settle();
    check("wrap.valid", {31'd0, out_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    expect_word("wrap0", 32'hFFFF_FFF8);
    next_cycle();
    settle();
    expect_word("wrap1", 32'hFFFF_FFFC);
    next_cycle();
    settle();
    expect_word("wrap2", 32'h0000_0000);
    check("wrap2.instr_abs", out_instr, 32'h0000_0001);

    // Reset pulsed with a full queue
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      out_ready = 1'b0;
      settle();
    end
    check("mrst.count_before", {30'd0, dut.fifo_count}, 32'd2);
    check("mrst.valid_before", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    settle();
    check("mrst.valid", {31'd0, out_valid}, 32'd0);
    check("mrst.count", {30'd0, dut.fifo_count}, 32'd0);
    check("mrst.addr",  imem_addr, 32'h0);
    next_cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    settle();
    check("mrst.rel_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      expect_word("mrst.restart", 32'(i * 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
